clint_mtimer: RTL and testbench
===============================

// Module: clint_mtimer
// PURPOSE
//  Machine timer and software-interrupt unit on the core's memory bus.
//  Holds 64-bit mtime, mtimecmp and msip. Drives tmr_irq_o into the interrupt controller's tmr_irq_i input.
//  Registers are mapped at the standard CLINT offsets and use a req/ack handshake with 1-cycle read latency.
// PARAMETERS
//  TICK_DIV   1        clk cycles per mtime increment (>=1); 1 = increment every cycle
//  BASE_MSIP  16'h0000 offset of msip (bit0 only; other bits read 0)
//  BASE_CMP   16'h4000 offset of mtimecmp (64-bit)
//  BASE_TIME  16'hBFF8 offset of mtime (64-bit)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, synchronous, active-low
//  time_en_i  in   1   count enable; 0 freezes mtime and the prescaler (debug halt)
//  req_i      in   1   bus request, one access per asserted cycle
//  we_i       in   1   1 = write, 0 = read (sampled with req_i)
//  addr_i     in   16  byte offset, 8-byte aligned; addr_i[2:0] ignored
//  wdata_i    in   64  write data, full 64-bit writes only
//  rdata_o    out  64  read data, valid while ack_o=1
//  ack_o      out  1   1-cycle pulse, the cycle after each accepted req_i
//  err_o      out  1   pulses with ack_o when the address is unmapped
//  tmr_irq_o  out  1   machine timer interrupt, level
//  sw_irq_o   out  1   machine software interrupt, level (= msip[0])
// BEHAVIOUR
//  Reset values:
//   - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0
//   - ack_o=0, err_o=0, rdata_o=0, tmr_irq_o=0, sw_irq_o=0
//   - Reset mid-access drops the access: no ack follows.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 while time_en_i=1.
//   - mtime += 1 in the cycle the count equals TICK_DIV-1; the count then returns to 0.
//   - mtime wraps from 2^64-1 to 0 with no flag.
//  Bus handshake:
//   - No stall; every cycle with req_i=1 is accepted.
//   - ack_o=1 exactly one cycle later; back-to-back requests give back-to-back acks.
//   - Reads return register values as they were in the request cycle, before any same-cycle increment.
//   - Writes take effect at the end of the request cycle.
//   - Unmapped offset: write ignored, read returns 0, err_o=1 with ack_o.
//   - ack_o=0 implies rdata_o=0 and err_o=0.
//  Priority:
//   - A software write to mtime overrides the same-cycle increment and clears the prescaler to 0.
//   - A write to mtimecmp or msip never affects mtime.
//  Interrupts:
//   - Compare is unsigned 64-bit: tmr_irq_o(n+1) = (mtime(n) >= mtimecmp(n)), registered.
//   - tmr_irq_o stays high until mtimecmp is raised above mtime, or mtime is written below it.
//   - Wrap of mtime to 0 deasserts tmr_irq_o one cycle later, unless mtimecmp=0.
//   - sw_irq_o = msip[0], registered, updates the cycle after the write.
//   - Writes to msip[63:1] are discarded.
//  State:
//   - Bus side has two states, IDLE and RESP. RESP lasts one cycle per accepted req_i.
//   - If req_i is high in RESP, the next state is RESP again.
// TESTING
//  T1 reset: hold rst_n=0 5 cycles -> all outputs 0; mtimecmp reads FFFF_FFFF_FFFF_FFFF; mtime reads 0 one cycle after release.
//  T2 prescale: TICK_DIV=4, time_en_i=1 for 40 cycles -> mtime=10; time_en_i=0 for 8 cycles -> mtime still 10.
//  T3 compare: mtimecmp=20, TICK_DIV=1 -> tmr_irq_o rises the cycle after mtime=20; write mtimecmp=100 -> falls 2 cycles after the write req.
//  T4 wrap/priority: write mtime=FFFF_FFFF_FFFF_FFFE with mtimecmp=FFFF_FFFF_FFFF_FFFF -> irq high at max, low after wrap to 0; write mtime=5 in a tick cycle -> mtime=5, not 6.
//  T5 bus: back-to-back read mtime, read msip, read 0x1234 -> ack_o 3 consecutive cycles; third has rdata_o=0 and err_o=1; write msip=3 -> sw_irq_o=1, msip reads 1.
//  T6 reset mid-op: assert rst_n=0 in the cycle after req_i -> no ack_o; mtime=0; tmr_irq_o=0.

Source files
------------

// File: rtl/clint_mtimer.sv
// Machine timer / software-interrupt unit (CLINT subset).
// Holds 64-bit mtime, mtimecmp and msip behind a req/ack bus with
// 1-cycle read latency. Drives level timer and software interrupts.
module clint_mtimer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [15:0] BASE_MSIP = 16'h0000,
  parameter logic [15:0] BASE_CMP  = 16'h4000,
  parameter logic [15:0] BASE_TIME = 16'hBFF8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        time_en_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        tmr_irq_o,
  output logic        sw_irq_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StIdle, StResp} bus_state_e;

  bus_state_e     state_q, state_d;
  logic [63:0]    mtime_q, mtime_d;
  logic [63:0]    mtimecmp_q, mtimecmp_d;
  logic           msip_q, msip_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [63:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           tmr_irq_q;

  logic sel_msip, sel_cmp, sel_time, mapped, tick;
  logic wr_msip, wr_cmp, wr_time;

  // Byte offset bits [2:0] carry no information for 8-byte registers.
  logic unused_addr;
  assign unused_addr = ^addr_i[2:0];

  // Address decode on the 8-byte word index.
  always_comb begin
    sel_msip = (addr_i[15:3] == BASE_MSIP[15:3]);
    sel_cmp  = (addr_i[15:3] == BASE_CMP[15:3]);
    sel_time = (addr_i[15:3] == BASE_TIME[15:3]);
    mapped   = sel_msip | sel_cmp | sel_time;
    wr_msip  = req_i & we_i & sel_msip;
    wr_cmp   = req_i & we_i & sel_cmp;
    wr_time  = req_i & we_i & sel_time;
    tick     = time_en_i & (presc_q == PRESC_MAX);
  end

  // Timer next state: a software write to mtime beats the same-cycle tick.
  always_comb begin
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_time) begin
      mtime_d = wdata_i;
      presc_d = '0;
    end else if (time_en_i) begin
      if (tick) begin
        mtime_d = mtime_q + 64'd1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (wr_cmp) begin
      mtimecmp_d = wdata_i;
    end
    if (wr_msip) begin
      msip_d = wdata_i[0];
    end
  end

  // Bus FSM and read-data capture; reads see pre-update register values.
  always_comb begin
    state_d = req_i ? StResp : StIdle;
    rdata_d = '0;
    err_d   = 1'b0;
    if (req_i) begin
      err_d = ~mapped;
      if (!we_i) begin
        if (sel_msip) begin
          rdata_d = {63'd0, msip_q};
        end else if (sel_cmp) begin
          rdata_d = mtimecmp_q;
        end else if (sel_time) begin
          rdata_d = mtime_q;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      presc_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmr_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      presc_q    <= presc_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmr_irq_q  <= (mtime_q >= mtimecmp_q);
    end
  end

  // Outputs; the response is gated by rst_n so a reset in the response
  // cycle drops the pending ack.
  always_comb begin
    ack_o     = rst_n & (state_q == StResp);
    rdata_o   = ack_o ? rdata_q : 64'd0;
    err_o     = ack_o & err_q;
    tmr_irq_o = tmr_irq_q;
    sw_irq_o  = msip_q;
  end

endmodule

// File: tb/tb_clint_mtimer.sv
// Directed self-checking bench for clint_mtimer. Two instances share all
// inputs: dut uses TICK_DIV=1, dut4 uses TICK_DIV=4.
module tb_clint_mtimer;

  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CMP  = 16'h4000;
  localparam logic [15:0] A_TIME = 16'hBFF8;
  localparam logic [15:0] A_BAD  = 16'h1234;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        time_en = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] wdata = '0;

  logic [63:0] rdata, rdata4;
  logic        ack, ack4, err, err4, tmr, tmr4, sw, sw4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clint_mtimer #(.TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .time_en_i(time_en), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .err_o(err),
    .tmr_irq_o(tmr), .sw_irq_o(sw)
  );

  clint_mtimer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .time_en_i(time_en), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata4), .ack_o(ack4), .err_o(err4),
    .tmr_irq_o(tmr4), .sw_irq_o(sw4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One-cycle read; returns the response sampled in the ack cycle.
  task automatic bus_read(input logic [15:0] a, output logic [63:0] rd,
                          output logic [63:0] rd4, output logic ak, output logic er);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
    rd = rdata; rd4 = rdata4; ak = ack; er = err;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [63:0] d,
                           output logic ak, output logic er);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
    ak = ack; er = err;
  endtask

  task automatic test_reset();
    logic [63:0] rd, rd4;
    logic ak, er;
    time_en = 1'b0;
    rst_n = 1'b0;
    repeat (5) tick();
    checks++; if ({ack, err, tmr, sw} !== 4'b0) begin
      errors++; $display("FAIL reset_outs: got %b expected 0000", {ack, err, tmr, sw});
    end
    checks++; if (rdata !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    checks++; if ({ack4, err4, tmr4, sw4} !== 4'b0 || rdata4 !== 64'd0) begin
      errors++; $display("FAIL reset_outs4: got %b/%h expected 0", {ack4, err4, tmr4, sw4}, rdata4);
    end
    rst_n = 1'b1;
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (ak !== 1'b1 || rd !== 64'd0) begin
      errors++; $display("FAIL reset_mtime: got ack=%b %h expected ack=1 0", ak, rd);
    end
    bus_read(A_CMP, rd, rd4, ak, er);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || rd4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_mtimecmp: got %h/%h expected all ones", rd, rd4);
    end
  endtask

  task automatic test_prescale();
    logic [63:0] rd, rd4;
    logic ak, er;
    do_reset();
    time_en = 1'b1;
    repeat (40) tick();
    time_en = 1'b0;
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (rd4 !== 64'd10) begin
      errors++; $display("FAIL prescale_div4: got %0d expected 10", rd4);
    end
    checks++; if (rd !== 64'd40) begin
      errors++; $display("FAIL prescale_div1: got %0d expected 40", rd);
    end
    repeat (8) tick();
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (rd4 !== 64'd10) begin
      errors++; $display("FAIL prescale_halt: got %0d expected 10", rd4);
    end
  endtask

  task automatic test_compare();
    logic ak, er;
    do_reset();
    bus_write(A_CMP, 64'd20, ak, er);
    time_en = 1'b1;
    repeat (20) tick();
    checks++; if (tmr !== 1'b0) begin
      errors++; $display("FAIL cmp_before: got %b expected 0", tmr);
    end
    tick();
    checks++; if (tmr !== 1'b1) begin
      errors++; $display("FAIL cmp_rise: got %b expected 1", tmr);
    end
    bus_write(A_CMP, 64'd100, ak, er);
    checks++; if (tmr !== 1'b1 || ak !== 1'b1) begin
      errors++; $display("FAIL cmp_hold: got irq=%b ack=%b expected 1 1", tmr, ak);
    end
    tick();
    checks++; if (tmr !== 1'b0) begin
      errors++; $display("FAIL cmp_fall: got %b expected 0", tmr);
    end
    time_en = 1'b0;
  endtask

  task automatic test_wrap_priority();
    logic [63:0] rd, rd4;
    logic ak, er;
    time_en = 1'b0;
    bus_write(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, ak, er);
    bus_write(A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, ak, er);
    time_en = 1'b1;
    tick();
    checks++; if (tmr !== 1'b0) begin
      errors++; $display("FAIL wrap_pre: got %b expected 0", tmr);
    end
    tick();
    checks++; if (tmr !== 1'b1) begin
      errors++; $display("FAIL wrap_max: got %b expected 1", tmr);
    end
    tick();
    checks++; if (tmr !== 1'b0) begin
      errors++; $display("FAIL wrap_zero: got %b expected 0", tmr);
    end
    bus_write(A_TIME, 64'd5, ak, er);
    time_en = 1'b0;
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (rd !== 64'd5) begin
      errors++; $display("FAIL write_priority: got %0d expected 5", rd);
    end
  endtask

  task automatic test_bus();
    logic [63:0] rd, rd4;
    logic ak, er;
    time_en = 1'b0;
    req = 1'b1; we = 1'b0; addr = A_TIME;
    tick();
    checks++; if (ack !== 1'b1 || rdata !== 64'd5 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_1: got ack=%b err=%b %h expected 1 0 5", ack, err, rdata);
    end
    addr = A_MSIP;
    tick();
    checks++; if (ack !== 1'b1 || rdata !== 64'd0 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_2: got ack=%b err=%b %h expected 1 0 0", ack, err, rdata);
    end
    addr = A_BAD;
    tick();
    req = 1'b0;
    checks++; if (ack !== 1'b1 || rdata !== 64'd0 || err !== 1'b1) begin
      errors++; $display("FAIL b2b_3: got ack=%b err=%b %h expected 1 1 0", ack, err, rdata);
    end
    tick();
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL ack_drop: got ack=%b err=%b expected 0 0", ack, err);
    end
    bus_write(A_MSIP, 64'd3, ak, er);
    checks++; if (sw !== 1'b1 || ak !== 1'b1 || er !== 1'b0) begin
      errors++; $display("FAIL msip_irq: got sw=%b ack=%b err=%b expected 1 1 0", sw, ak, er);
    end
    bus_read(A_MSIP, rd, rd4, ak, er);
    checks++; if (rd !== 64'd1) begin
      errors++; $display("FAIL msip_read: got %h expected 1", rd);
    end
    bus_write(A_BAD, 64'hDEAD, ak, er);
    checks++; if (ak !== 1'b1 || er !== 1'b1) begin
      errors++; $display("FAIL bad_write: got ack=%b err=%b expected 1 1", ak, er);
    end
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (rd !== 64'd5) begin
      errors++; $display("FAIL mtime_kept: got %0d expected 5", rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] rd, rd4;
    logic ak, er;
    time_en = 1'b0;
    bus_write(A_CMP, 64'd0, ak, er);
    tick();
    checks++; if (tmr !== 1'b1) begin
      errors++; $display("FAIL midop_irq_pre: got %b expected 1", tmr);
    end
    req = 1'b1; we = 1'b0; addr = A_TIME;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0 || rdata !== 64'd0) begin
      errors++; $display("FAIL midop_ack: got ack=%b %h expected 0 0", ack, rdata);
    end
    tick();
    checks++; if (ack !== 1'b0 || tmr !== 1'b0 || sw !== 1'b0) begin
      errors++; $display("FAIL midop_state: got ack=%b irq=%b sw=%b expected 0", ack, tmr, sw);
    end
    rst_n = 1'b1;
    bus_read(A_TIME, rd, rd4, ak, er);
    checks++; if (rd !== 64'd0 || tmr !== 1'b0) begin
      errors++; $display("FAIL midop_mtime: got %h irq=%b expected 0 0", rd, tmr);
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_compare();
    test_wrap_priority();
    test_bus();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
